// File: rtl/sum_arbiter_ctrl.sv
// sum_arbiter_ctrl: two-requester round-robin arbiter in front of a serial
// triangular-number engine. The winning requester's N is summed as
// N + (N-1) + ... + 1 one term per cycle; the result is published on rout
// with a one-cycle done pulse tagged with the owner id.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for req0/req1; arbitrates and latches winner's N
// S_ACCUM | adds cnt into temp and decrements cnt until cnt reaches 0
// S_DONE  | done pulse cycle; returns to IDLE without sampling requests
module sum_arbiter_ctrl #(
    parameter int NW = 4,
    parameter int SW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [NW-1:0] n0,
    input  logic          req1,
    input  logic [NW-1:0] n1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [SW-1:0] rout,
    output logic [SW-1:0] temp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          cur_id_q, cur_id_d;
    logic          last_q, last_d;
    logic [SW-1:0] temp_q, temp_d;
    logic [SW-1:0] rout_q, rout_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          done_id_q, done_id_d;
    logic          win;

    // Round-robin: a lone request wins; on a tie the side not granted last wins.
    assign win = req1 & (~req0 | ~last_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_id_d  = cur_id_q;
        last_d    = last_q;
        temp_d    = temp_q;
        rout_d    = rout_q;
        done_id_d = done_id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    cnt_d    = win ? n1 : n0;
                    cur_id_d = win;
                    last_d   = win;
                    temp_d   = '0;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (cnt_q != '0) begin
                    temp_d = temp_q + {{(SW-NW){1'b0}}, cnt_q};
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    rout_d    = temp_q;
                    done_d    = 1'b1;
                    done_id_d = cur_id_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cur_id_q  <= 1'b0;
            last_q    <= 1'b1;
            temp_q    <= '0;
            rout_q    <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_id_q  <= cur_id_d;
            last_q    <= last_d;
            temp_q    <= temp_d;
            rout_q    <= rout_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign rout    = rout_q;
    assign temp    = temp_q;

endmodule

// File: tb/tb_sum_arbiter_ctrl.sv
// Bench for sum_arbiter_ctrl: job-level reference model (closed-form sums,
// cycle offset since grant) checked every cycle, directed scenarios with
// literal expectations, then randomized requesters with sporadic resets.
module tb_sum_arbiter_ctrl;

    localparam int NW = 4;
    localparam int SW = 7;

    logic          clk;
    logic          rst_n;
    logic          req0, req1;
    logic [NW-1:0] n0, n1;
    logic          gnt0, gnt1, busy, done, done_id;
    logic [SW-1:0] rout, temp;

    int checks = 0;
    int errors = 0;

    sum_arbiter_ctrl #(.NW(NW), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .n0(n0), .req1(req1), .n1(n1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .done_id(done_id), .rout(rout), .temp(temp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a job is (owner, N, k = edges since the grant edge).
    int m_active = 0, m_k = 0, m_n = 0, m_id = 0, m_last = 1, mm;
    int e_gnt0 = 0, e_gnt1 = 0, e_busy = 0, e_done = 0, e_done_id = 0;
    int e_rout = 0, e_temp = 0;
    bit model_ok = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_last = 1; m_k = 0;
            e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_done = 0; e_done_id = 0;
            e_rout = 0; e_temp = 0;
        end else begin
            if (m_active != 0) begin
                m_k++;
                if (m_k == m_n + 2) m_active = 0;
            end else if (req0 || req1) begin
                if (req0 && req1) m_id = 1 - m_last;
                else              m_id = req1 ? 1 : 0;
                m_last   = m_id;
                m_n      = (m_id == 1) ? int'(n1) : int'(n0);
                m_k      = 0;
                m_active = 1;
            end
            e_gnt0 = (m_active != 0 && m_k == 0 && m_id == 0) ? 1 : 0;
            e_gnt1 = (m_active != 0 && m_k == 0 && m_id == 1) ? 1 : 0;
            e_busy = m_active;
            e_done = (m_active != 0 && m_k == m_n + 1) ? 1 : 0;
            if (m_active != 0) begin
                mm     = (m_k < m_n) ? m_k : m_n;
                e_temp = mm * m_n - (mm * (mm - 1)) / 2;
            end
            if (e_done != 0) begin
                e_rout    = (m_n * (m_n + 1)) / 2;
                e_done_id = m_id;
            end
        end
        model_ok = 1;
    end

    // Per-cycle comparison against the model, plus exclusivity invariants.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("gnt0", gnt0, e_gnt0);
            chk("gnt1", gnt1, e_gnt1);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("done_id", done_id, e_done_id);
            chk("rout", rout, e_rout);
            chk("temp", temp, e_temp);
            chk("gnt_excl", gnt0 & gnt1, 0);
            chk("done_vs_gnt", done & (gnt0 | gnt1), 0);
        end
    end

    task automatic run_job(input int who, input int n, input int exp_rout, input int exp_busy);
        int busy_cnt = 0;
        int got_done = 0;
        if (who == 0) begin req0 = 1'b1; n0 = NW'(n); end
        else          begin req1 = 1'b1; n1 = NW'(n); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (busy) busy_cnt++;
            if (who == 0 && gnt0) req0 = 1'b0;
            if (who == 1 && gnt1) req1 = 1'b0;
            if (done) begin
                got_done = 1;
                chk("job_rout", rout, exp_rout);
                chk("job_done_id", done_id, who);
            end
            if (!busy && busy_cnt > 0) break;
        end
        chk("job_done_seen", got_done, 1);
        chk("job_busy_len", busy_cnt, exp_busy);
    endtask

    int rres[4];
    int rid[4];
    int idx;
    int seen_gnt;
    int seen_done;

    initial begin
        rst_n = 1'b0; req0 = 1'b1; n0 = 4'd5; req1 = 1'b0; n1 = '0;

        // Reset held two cycles with a request pending.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_temp", temp, 0);
        chk("rst_rout", rout, 0);
        req0 = 1'b0; rst_n = 1'b1;
        @(negedge clk); #1;

        run_job(0, 2, 3, 4);
        run_job(1, 15, 120, 17);

        // Both held: alternating grants starting with requester 0.
        req0 = 1'b1; n0 = 4'd4; req1 = 1'b1; n1 = 4'd5; idx = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk); #1;
            if (done && idx < 4) begin
                rres[idx] = int'(rout); rid[idx] = int'(done_id); idx++;
                if (idx == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
            if (idx == 4 && !busy) break;
        end
        chk("rr_count", idx, 4);
        for (int j = 0; j < 4; j++) begin
            chk("rr_rout", rres[j], (j % 2 == 0) ? 10 : 15);
            chk("rr_id", rid[j], j % 2);
        end

        run_job(0, 0, 0, 2);

        // Reset at E0+4 aborts a job.
        req0 = 1'b1; n0 = 4'd9; seen_gnt = 0; seen_done = 0;
        for (int i = 0; i < 5 && seen_gnt == 0; i++) begin
            @(negedge clk); #1;
            if (gnt0) seen_gnt = 1;
        end
        chk("abort_gnt_seen", seen_gnt, 1);
        req0 = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            if (done) seen_done = 1;
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        if (done) seen_done = 1;
        chk("abort_no_done", seen_done, 0);
        chk("abort_rout", rout, 0);
        chk("abort_temp", temp, 0);
        chk("abort_busy", busy, 0);
        rst_n = 1'b1;
        run_job(1, 3, 6, 5);

        // Randomized requesters that obey the hold-until-grant rule.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            rst_n = ($urandom_range(0, 299) != 0);
            if (gnt0) begin
                if ($urandom_range(0, 1) == 1) req0 = 1'b0;
                else n0 = NW'($urandom_range(0, 15));
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; n0 = NW'($urandom_range(0, 15));
            end
            if (gnt1) begin
                if ($urandom_range(0, 1) == 1) req1 = 1'b0;
                else n1 = NW'($urandom_range(0, 15));
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; n1 = NW'($urandom_range(0, 15));
            end
        end

        // Drain: a still-pending request may be granted once more.
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if (!busy && !req0 && !req1) break;
        end
        chk("drain_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_arbiter_ctrl.md
SUM_ARBITER_CTRL -- requirements
Module: sum_arbiter_ctrl

Interface
REQ-001 Parameter: NW, 4, width of each requester's N operand.
REQ-002 Parameter: SW, 7, width of accumulator and result; SHALL satisfy 2^SW > (2^NW-1)*2^NW/2 (default 120 < 128).
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req0  input  1  requester 0 summation request, level.
REQ-006 n0  input  NW  requester 0 operand N, sampled with req0.
REQ-007 req1  input  1  requester 1 summation request, level.
REQ-008 n1  input  NW  requester 1 operand N, sampled with req1.
REQ-009 gnt0  output  1  one-cycle grant/acknowledge to requester 0.
REQ-010 gnt1  output  1  one-cycle grant/acknowledge to requester 1.
REQ-011 busy  output  1  high whenever FSM is not in IDLE.
REQ-012 done  output  1  one-cycle pulse, rout valid and updated.
REQ-013 done_id  output  1  requester owning the result on done (0/1).
REQ-014 rout  output  SW  final sum 1+2+...+N, held until next done.
REQ-015 temp  output  SW  running accumulator, visible every cycle.

Function
REQ-016 FSM SHALL have three states: IDLE, ACCUM, DONE; all outputs registered.
REQ-017 IDLE: at an edge with req0 or req1 high, SHALL latch winner's N into cnt, winner id into cur_id, clear temp to 0, go ACCUM, assert matching gntX for exactly the following cycle.
REQ-018 Arbitration SHALL be round-robin: single request wins; both requesting -> grant the requester not granted last; last-granted pointer resets to 1 (req0 wins first tie).
REQ-019 ACCUM, cnt != 0: each edge SHALL do temp <= temp + cnt, cnt <= cnt - 1, stay ACCUM.
REQ-020 ACCUM, cnt == 0: edge SHALL do rout <= temp, done <= 1, done_id <= cur_id, go DONE.
REQ-021 DONE: next edge SHALL clear done and return to IDLE; requests not sampled in ACCUM or DONE.
REQ-022 Latency: sampling edge E0 -> done high after edge E0+N+1; busy high N+2 cycles; IDLE lasts at least one cycle between jobs.
REQ-023 N = 0 SHALL give one ACCUM cycle, rout = 0, done after E0+1.
REQ-024 Additions SHALL be unsigned, zero-extended to SW bits; no overflow possible per REQ-002.
REQ-025 Requester SHALL hold req and N stable until its gnt; req still high after gnt is a new request.
REQ-026 Operand changes during ACCUM SHALL not affect the job in progress.
REQ-027 gnt0 and gnt1 SHALL never be high together; done SHALL never coincide with gnt.

Reset
REQ-028 rst_n low at an edge SHALL force IDLE, gnt0=gnt1=busy=done=done_id=0, rout=0, temp=0, cnt=0, pointer=1, from any state.
REQ-029 Reset during ACCUM or DONE SHALL abort the job with no done pulse; first request after release handled normally.

Verification
REQ-030 Reset: rst_n low 2 cycles with req0=1 -> all outputs 0, no gnt.
REQ-031 req0=1, n0=2 -> gnt0 1 cycle after E0; temp 0,2,3; done at E0+3, rout=3, done_id=0; busy 4 cycles.
REQ-032 req1=1, n1=15 -> gnt1; done at E0+16, rout=120 (0x78), done_id=1; busy 17 cycles.
REQ-033 req0=req1=1 held, n0=4, n1=5 -> grants 0,1,0,1; rout 10,15,10,15; done_id alternates.
REQ-034 req0=1, n0=0 -> gnt0 then done at E0+1, rout=0; temp stays 0.
REQ-035 req0=1, n0=9, rst_n low at E0+4 -> no done, rout=0, temp=0; post-release req1 n1=3 -> rout=6, done_id=1.
